// File: rtl/fp32_to_int32.sv
// fp32_to_int32: multi-cycle IEEE-754 single precision to signed 32-bit
// integer converter with round-to-nearest-even, valid/ready on both sides.
// Optional build macro FP32_TO_INT32_BARREL_EN replaces the iterative
// one-bit-per-cycle denormalizing shift with a single-cycle barrel shift.
module fp32_to_int32 #(
  parameter int unsigned MAX_RSHIFT = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_res,
  output logic        out_ovf,
  output logic        out_nx
);

  typedef enum logic [2:0] {IDLE, UNPACK, SHIFT, ROUND, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] a_q, a_d;
  logic        s_q, s_d;
  logic [31:0] mag_q, mag_d;
  logic        guard_q, guard_d;
  logic        sticky_q, sticky_d;
  logic [31:0] res_q, res_d;
  logic        ovf_q, ovf_d;
  logic        nx_q, nx_d;

`ifndef FP32_TO_INT32_BARREL_EN
  localparam int unsigned CW = $clog2(MAX_RSHIFT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
`else
  logic [55:0]   wide;
`endif

  logic [7:0]  e;
  logic [22:0] frac;
  logic [23:0] m;
  logic [7:0]  n;
  logic        inc;
  logic [31:0] mag_r;

  assign e        = a_q[30:23];
  assign frac     = a_q[22:0];
  assign m        = {1'b1, frac};
  assign n        = 8'd150 - e;
  assign inc      = guard_q & (sticky_q | mag_q[0]);
  assign mag_r    = mag_q + 32'(inc);

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_res   = res_q;
  assign out_ovf   = ovf_q;
  assign out_nx    = nx_q;

  // Next-state and datapath updates for the conversion sequence
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    s_d      = s_q;
    mag_d    = mag_q;
    guard_d  = guard_q;
    sticky_d = sticky_q;
    res_d    = res_q;
    ovf_d    = ovf_q;
    nx_d     = nx_q;
`ifndef FP32_TO_INT32_BARREL_EN
    cnt_d    = cnt_q;
`else
    wide     = {m, 32'b0} >> n;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          state_d = UNPACK;
        end
      end
      UNPACK: begin
        s_d      = a_q[31];
        mag_d    = '0;
        guard_d  = 1'b0;
        sticky_d = 1'b0;
        if (e == 8'hFF) begin
          res_d   = (a_q[31] && frac == '0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
          ovf_d   = 1'b1;
          nx_d    = 1'b0;
          state_d = DONE;
        end else if (e == 8'h00) begin
          sticky_d = |frac;
          state_d  = ROUND;
        end else if (e >= 8'd158) begin
          res_d   = a_q[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
          ovf_d   = !(e == 8'd158 && a_q[31] && frac == '0);
          nx_d    = 1'b0;
          state_d = DONE;
        end else if (e >= 8'd150) begin
          mag_d   = 32'(m) << (e - 8'd150);
          state_d = ROUND;
        end else if (32'(n) <= MAX_RSHIFT) begin
`ifdef FP32_TO_INT32_BARREL_EN
          // Guard lands at bit 31 of the shifted window; everything below is sticky.
          mag_d    = 32'(wide[55:32]);
          guard_d  = wide[31];
          sticky_d = |wide[30:0];
          state_d  = ROUND;
`else
          mag_d   = 32'(m);
          cnt_d   = CW'(n);
          state_d = SHIFT;
`endif
        end else begin
          sticky_d = 1'b1;
          state_d  = ROUND;
        end
      end
`ifndef FP32_TO_INT32_BARREL_EN
      SHIFT: begin
        sticky_d = sticky_q | guard_q;
        guard_d  = mag_q[0];
        mag_d    = mag_q >> 1;
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = ROUND;
      end
`endif
      ROUND: begin
        res_d   = s_q ? (-mag_r) : mag_r;
        nx_d    = guard_q | sticky_q;
        ovf_d   = 1'b0;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      s_q      <= 1'b0;
      mag_q    <= '0;
      guard_q  <= 1'b0;
      sticky_q <= 1'b0;
      res_q    <= '0;
      ovf_q    <= 1'b0;
      nx_q     <= 1'b0;
`ifndef FP32_TO_INT32_BARREL_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      s_q      <= s_d;
      mag_q    <= mag_d;
      guard_q  <= guard_d;
      sticky_q <= sticky_d;
      res_q    <= res_d;
      ovf_q    <= ovf_d;
      nx_q     <= nx_d;
`ifndef FP32_TO_INT32_BARREL_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

endmodule
